event_encoder_8to3: RTL
=======================

Name: event_encoder_8to3

Overview:
- Registered 8-to-3 request encoder; the return path for the 3-to-8 select decoders.
- Latches eight single-bit request lines into a pending register.
- Offers the index of the highest-priority pending request as a 3-bit code with a valid/ack handshake.
- Clears each request only after the consumer acknowledges it.
- Sits between the decoded D0..D7 domain and any block that needs the selected line number back as s2..s0.

Parameters:
- LOW_FIRST, 1, priority order: 1 = bit 0 highest (D0 wins); 0 = bit 7 highest (D7 wins).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- E  input  1  offer enable; 0 blocks new offers, capture continues.
- req  input  8  request lines; bit i set = request from line Di (level or pulse).
- ack  input  1  consumer accepts the current code; only meaningful while valid=1.
- ovf_clr  input  1  clears the sticky overflow flag.
- code  output  3  encoded index {s2,s1,s0} of the offered request.
- valid  output  1  code is valid and held stable until ack.
- pending  output  8  current pending register.
- overflow  output  1  sticky flag: a request hit an already-pending bit.

Behaviour:
- Reset (rst_n=0, asynchronous): pending=0, code=0, valid=0, overflow=0, state=IDLE. Applies immediately, including mid-offer. No partial state survives.
- Pending register, each edge: pending_next = (pending & ~clr_mask) | req.
  - clr_mask is one-hot at code when a handshake completes (valid & ack), otherwise 0.
  - Set dominates clear: a req on the bit being acknowledged keeps it pending.
- Overflow, each edge: set if any bit i has req[i]=1, pending[i]=1 and bit i is not being cleared that cycle. ovf_clr=1 clears it. If set and clear occur in the same cycle, set wins. Once set, the flag holds until ovf_clr or reset.
- FSM has two states:
  - IDLE: valid=0. If E=1 and pending!=0, register code = priority index of pending (per LOW_FIRST), drive valid=1, go to OFFER. Otherwise stay in IDLE.
  - OFFER: valid=1 and code frozen. Requests arriving, including higher-priority ones, do not preempt the offer, and E=0 does not withdraw it. On ack=1 the bit is cleared, valid goes to 0 and the FSM returns to IDLE on the same edge.
- Latency:
  - A req first sampled at edge k appears in pending after k, and valid/code appear after edge k+1 (2-cycle request-to-offer).
  - After an ack at edge m, the earliest next offer is after edge m+1. There is always at least one cycle with valid=0 between grants.
- ack while valid=0 is ignored and has no effect on pending.
- All 8 bits pending: the requests are served one per handshake in priority order. No starvation within a batch, because already-served bits are cleared.
- E=0 with pending!=0: stay in IDLE and keep accumulating requests. Offers start the cycle after E returns to 1, using priority over the full accumulated set.
- code is only meaningful while valid=1; it holds its last value while in IDLE.

Test Plan:
- Reset then single request: req=8'b0010_0000 for one cycle → pending=8'h20 after that edge; valid=1, code=3'd5 one edge later; ack one cycle → pending=0, valid=0.
- Priority, LOW_FIRST=1: req=8'b1001_0100 pulsed → codes offered in order 2, 4, 7, each followed by ack. Repeat with LOW_FIRST=0 → order 7, 4, 2. Check valid=0 for ≥1 cycle between each grant.
- No preemption: while code=5 is offered and unacked, pulse req[0] → code stays 5 until ack; next offer is code=0.
- Overflow and set-dominance:
  - With pending[3]=1 and no ack, pulse req[3] → overflow=1; assert ovf_clr → overflow=0.
  - Separately, req[3] coincident with ack of code 3 → pending[3] stays 1, overflow stays 0, and code 3 is re-offered.
- Enable gating: E=0, req=8'hFF pulsed → valid stays 0 and pending=8'hFF. Raise E → valid=1, code=0 on the next edge.
- Asynchronous reset mid-offer: valid=1, code=6, drop rst_n between clock edges → valid, code, pending and overflow all go to 0 immediately. After release, no offer appears until a new req arrives.

Source files
------------

// File: rtl/event_encoder_8to3.sv
// Registered 8-to-3 request encoder: captures request lines into a pending
// register and offers the highest-priority index through a valid/ack handshake.
module event_encoder_8to3 #(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       E,
    input  logic [7:0] req,
    input  logic       ack,
    input  logic       ovf_clr,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending,
    output logic       overflow
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t     state;
    logic [7:0] clr_mask;
    logic [7:0] pending_next;
    logic       ovf_hit;
    logic [2:0] pick;

    always_comb begin
        clr_mask = '0;
        if (valid && ack) begin
            clr_mask[code] = 1'b1;
        end
        // Set dominates clear: a new request on the acknowledged bit survives.
        pending_next = (pending & ~clr_mask) | req;
        ovf_hit      = |(req & pending & ~clr_mask);

        // Last match wins, so scan toward the highest-priority bit.
        pick = '0;
        if (LOW_FIRST) begin
            for (int unsigned i = 8; i > 0; i--) begin
                if (pending[i-1]) pick = 3'(i - 1);
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (pending[i]) pick = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= '0;
            code     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pending <= pending_next;
            if (ovf_hit) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (E && (pending != '0)) begin
                        code  <= pick;
                        valid <= 1'b1;
                        state <= OFFER;
                    end
                end
                OFFER: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
